saradc_sar_ctrl: RTL and testbench
==================================

// Module: saradc_sar_ctrl
// PURPOSE
//  Synchronous SAR conversion controller, directly upstream of saradc_logic_buf.
//  - Generates SAMPLE and VALID.
//  - Resolves comparator decisions MSB-first.
//  - Drives the RESULTP/RESULTN capacitor-DAC switch codes consumed by saradc_logic_buf.
//  - Returns the parallel output code DOUT with a DONE strobe.
// PARAMETERS
//  NBITS       8  conversion width; RESULTP/RESULTN cover bits NBITS-1..1
//  SMP_CYCLES  2  SAMPLE high time in CLK cycles, >=1
// PORTS
//  CLK      in   1        conversion clock; all state changes on rising edge
//  RST      in   1        reset; asynchronous, active-high
//  START    in   1        conversion request, sampled on CLK rising edge
//  CONT     in   1        1 = restart automatically after each conversion
//  COMPP    in   1        comparator positive output, valid at CLK rising edge
//  COMPN    in   1        comparator negative output, valid at CLK rising edge
//  SAMPLE   out  1        track phase, to saradc_logic_buf
//  VALID    out  1        1 = conversion finished / comparator disabled
//  RESULTP  out  NBITS-1  [NBITS-1:1] per-bit DAC switch, low side (CRL path)
//  RESULTN  out  NBITS-1  [NBITS-1:1] per-bit DAC switch, high side (CRH path)
//  DOUT     out  NBITS    last completed code
//  DONE     out  1        one-cycle pulse when DOUT updates
//  ERR      out  1        sticky flag: no-decision comparator result seen
// BEHAVIOUR
//  Reset values (RST=1, async): SAMPLE=0, VALID=1, RESULTP=0, RESULTN=0, DOUT=0, DONE=0, ERR=0, state=IDLE.
//  - RST mid-conversion aborts immediately to these values.
//  - No partial DOUT update and no DONE pulse on abort.
//  States:
//  - IDLE: wait for START.
//    - START=1 -> SMP, with SAMPLE<=1, VALID<=0, RESULTP/N<=0, smp_cnt<=0.
//  - SMP: SAMPLE held SMP_CYCLES cycles.
//    - When smp_cnt==SMP_CYCLES-1 -> CONV, with SAMPLE<=0, bit index k<=NBITS-1.
//  - CONV: one bit per cycle.
//    - The comparator fires during CLK low (saradc_logic_buf gates CMP with SAMPLE/VALID/CLK).
//    - Decision is captured on the next rising edge.
//  Decode at each CONV edge:
//  - {COMPP,COMPN}=10 -> bit k=1; =01 -> bit k=0.
//  - =00 or 11 -> bit k=0 and ERR<=1.
//  - For k>=1: bit=1 sets RESULTN[k]=1 / RESULTP[k]=0; bit=0 sets RESULTP[k]=1 / RESULTN[k]=0.
//  - Undecided bits keep both switches at 0.
//  - Bit 0 drives no DAC switch.
//  Completion (k==0 edge):
//  - DOUT<=full code, DONE<=1 for exactly one cycle, VALID<=1.
//  - RESULTP/N hold final value until the next SMP entry.
//  - Then: IDLE if CONT=0; SMP directly if CONT=1 (back-to-back, no IDLE cycle).
//  Timing, with START seen at edge t0:
//  - SAMPLE=1 over edges t0..t0+SMP_CYCLES.
//  - Bit NBITS-1-j is captured at edge t0+SMP_CYCLES+1+j.
//  - DONE is high after edge t0+SMP_CYCLES+NBITS.
//  - Conversion period with CONT=1: SMP_CYCLES+NBITS cycles.
//  Boundaries:
//  - START while not IDLE is ignored; no queuing.
//  - CONT deasserted mid-conversion finishes the current conversion, then goes to IDLE.
//  - ERR clears only on RST.
//  - SAMPLE and VALID are never high simultaneously.
//  - VALID=0 only during SMP/CONV.
//  All outputs are registered; no combinational path from any input to any output.
// TESTING  (NBITS=8, SMP_CYCLES=2)
//  1. Reset, then START pulse with comparator model for input code 0xA5.
//     -> SAMPLE high 2 cycles; DONE at t0+10; DOUT=0xA5.
//     -> RESULTN=7'b1010010, RESULTP=7'b0101101; ERR=0.
//  2. Forced all-10 decisions, then all-01.
//     -> DOUT=0xFF (RESULTN=7'h7F, RESULTP=0), then DOUT=0x00 (RESULTP=7'h7F, RESULTN=0).
//  3. CONT=1 for 3 conversions.
//     -> DONE pulses exactly 10 cycles apart; no IDLE gap; DOUT updates each time.
//     -> Drop CONT during the 3rd conversion -> IDLE after its DONE.
//  4. Assert RST asynchronously at bit 4 of a conversion.
//     -> Outputs equal reset values immediately without a clock edge; DOUT keeps 0; no DONE.
//  5. Drive {COMPP,COMPN}=11 on bit 3 only.
//     -> Bit 3=0, ERR=1 and stays 1 across the next clean conversion until RST.
//  6. START held high during CONV and pulsed in SMP -> ignored.
//     -> One conversion only; SAMPLE&VALID never both 1 (assertion).

Source files
------------

// File: rtl/saradc_sar_ctrl.sv
// rtl/saradc_sar_ctrl.sv - SAR conversion controller: sample timing, MSB-first bit resolution, DAC switch codes
module saradc_sar_ctrl #(
    parameter int NBITS      = 8,
    parameter int SMP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             compp,
    input  logic             compn,
    output logic             sample,
    output logic             valid,
    output logic [NBITS-1:1] resultp,
    output logic [NBITS-1:1] resultn,
    output logic [NBITS-1:0] dout,
    output logic             done,
    output logic             err
);
    localparam int KW = (NBITS > 2) ? $clog2(NBITS) : 1;
    localparam int SW = $clog2(SMP_CYCLES + 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(SMP_CYCLES - 1);
    localparam logic [KW-1:0] K_MSB    = KW'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, SMP, CONV} state_t;

    state_t           state, state_n;
    logic [SW-1:0]    smp_cnt, smp_cnt_n;
    logic [KW-1:0]    k, k_n;
    logic [NBITS-1:0] code, code_n, full_code;
    logic             sample_n, valid_n, done_n, err_n;
    logic [NBITS-1:1] resultp_n, resultn_n;
    logic [NBITS-1:0] dout_n;
    logic             dec_one, dec_zero, dec_bad;

    assign dec_one  = compp & ~compn;
    assign dec_zero = ~compp & compn;
    assign dec_bad  = ~(compp ^ compn);

    always_comb begin
        state_n   = state;
        smp_cnt_n = smp_cnt;
        k_n       = k;
        code_n    = code;
        full_code = code;
        sample_n  = sample;
        valid_n   = valid;
        resultp_n = resultp;
        resultn_n = resultn;
        dout_n    = dout;
        done_n    = 1'b0;
        err_n     = err;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = SMP;
                    sample_n  = 1'b1;
                    valid_n   = 1'b0;
                    resultp_n = '0;
                    resultn_n = '0;
                    smp_cnt_n = '0;
                    code_n    = '0;
                end
            end
            SMP: begin
                if (smp_cnt == SMP_LAST) begin
                    state_n  = CONV;
                    sample_n = 1'b0;
                    k_n      = K_MSB;
                end else begin
                    smp_cnt_n = smp_cnt + 1'b1;
                end
            end
            CONV: begin
                full_code[k] = dec_one;
                code_n       = full_code;
                if (dec_bad)
                    err_n = 1'b1;
                if (k != '0) begin
                    // undecided bits leave both switches open
                    resultn_n[k] = dec_one;
                    resultp_n[k] = dec_zero;
                    k_n          = k - 1'b1;
                end else begin
                    dout_n  = full_code;
                    done_n  = 1'b1;
                    if (cont) begin
                        state_n   = SMP;
                        sample_n  = 1'b1;
                        valid_n   = 1'b0;
                        resultp_n = '0;
                        resultn_n = '0;
                        smp_cnt_n = '0;
                        code_n    = '0;
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            smp_cnt <= '0;
            k       <= '0;
            code    <= '0;
            sample  <= 1'b0;
            valid   <= 1'b1;
            resultp <= '0;
            resultn <= '0;
            dout    <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            smp_cnt <= smp_cnt_n;
            k       <= k_n;
            code    <= code_n;
            sample  <= sample_n;
            valid   <= valid_n;
            resultp <= resultp_n;
            resultn <= resultn_n;
            dout    <= dout_n;
            done    <= done_n;
            err     <= err_n;
        end
    end
endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// tb/tb_saradc_sar_ctrl.sv - table-driven bench for saradc_sar_ctrl
module tb_saradc_sar_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, cont, compp, compn;
    logic       sample, valid, done, err;
    logic [7:1] resultp, resultn;
    logic [7:0] dout;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       excl_viol = 1'b0;

    saradc_sar_ctrl #(.NBITS(8), .SMP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .compp(compp), .compn(compn), .sample(sample), .valid(valid),
        .resultp(resultp), .resultn(resultn), .dout(dout),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && sample && valid)
            excl_viol <= 1'b1;

    typedef struct {
        logic [7:0] code;
        logic [7:0] bad;
        bit         do_start;
        bit         hold;
        bit         cont_start;
        bit         cont_end;
        logic [7:0] exp_dout;
        logic [6:0] exp_resn;
        logic [6:0] exp_resp;
        bit         exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        cont = v.cont_start;
        if (v.do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = v.hold;
            chk($sformatf("v%0d_done_t0", idx), 32'(done), 32'd0);
        end
        chk($sformatf("v%0d_sample_t0", idx), 32'(sample), 32'd1);
        chk($sformatf("v%0d_valid_t0", idx), 32'(valid), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_sample_t1", idx), 32'(sample), 32'd1);
        @(negedge clk);
        chk($sformatf("v%0d_sample_t2", idx), 32'(sample), 32'd0);
        chk($sformatf("v%0d_valid_t2", idx), 32'(valid), 32'd0);
        for (int j = 0; j < 8; j++) begin
            if (v.bad[7-j]) {compp, compn} = 2'b11;
            else            {compp, compn} = {v.code[7-j], ~v.code[7-j]};
            if (j == 3) cont = v.cont_end;
            if (j == 7) start = 1'b0;
            @(negedge clk);
            if (j < 7) chk($sformatf("v%0d_done_early_%0d", idx, j), 32'(done), 32'd0);
        end
        {compp, compn} = 2'b00;
        chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_dout", idx), 32'(dout), 32'(v.exp_dout));
        chk($sformatf("v%0d_resultn", idx), 32'(resultn), 32'(v.exp_resn));
        chk($sformatf("v%0d_resultp", idx), 32'(resultp), 32'(v.exp_resp));
        chk($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
        chk($sformatf("v%0d_valid_end", idx), 32'(valid), 32'(!v.cont_end));
        chk($sformatf("v%0d_sample_end", idx), 32'(sample), 32'(v.cont_end));
        if (!v.cont_end) begin
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", idx), 32'(done), 32'd0);
            chk($sformatf("v%0d_idle_valid", idx), 32'(valid), 32'd1);
            chk($sformatf("v%0d_idle_sample", idx), 32'(sample), 32'd0);
        end
    endtask

    initial begin
        //          code   bad    st hold cs ce  dout   resn   resp   err
        vecs[0] = '{8'hA5, 8'h00, 1, 0,  0, 0, 8'hA5, 7'h52, 7'h2D, 0};
        vecs[1] = '{8'hFF, 8'h00, 1, 0,  0, 0, 8'hFF, 7'h7F, 7'h00, 0};
        vecs[2] = '{8'h00, 8'h00, 1, 0,  0, 0, 8'h00, 7'h00, 7'h7F, 0};
        vecs[3] = '{8'h3C, 8'h00, 1, 1,  0, 0, 8'h3C, 7'h1E, 7'h61, 0};
        vecs[4] = '{8'h81, 8'h00, 1, 0,  1, 1, 8'h81, 7'h00, 7'h00, 0};
        vecs[5] = '{8'h7E, 8'h00, 0, 0,  1, 1, 8'h7E, 7'h00, 7'h00, 0};
        vecs[6] = '{8'hC3, 8'h00, 0, 0,  1, 0, 8'hC3, 7'h61, 7'h1E, 0};
        vecs[7] = '{8'hFF, 8'h08, 1, 0,  0, 0, 8'hF7, 7'h7B, 7'h00, 1};
        vecs[8] = '{8'h5A, 8'h00, 1, 0,  0, 0, 8'h5A, 7'h2D, 7'h52, 1};

        rst = 1'b1; start = 1'b0; cont = 1'b0; compp = 1'b0; compn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_valid", 32'(valid), 32'd1);
        chk("rst_resultp", 32'(resultp), 32'd0);
        chk("rst_resultn", 32'(resultn), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_valid", 32'(valid), 32'd1);

        for (int i = 0; i < 9; i++)
            run_vec(vecs[i], i);

        // abort mid-conversion after bits 7..4 of 0xA5 are resolved
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            {compp, compn} = {dut_code_bit(8'hA5, 7 - j), ~dut_code_bit(8'hA5, 7 - j)};
            @(negedge clk);
        end
        {compp, compn} = 2'b00;
        chk("abort_pre_resultn", 32'(resultn), 32'h50);
        chk("abort_pre_resultp", 32'(resultp), 32'h28);
        chk("abort_pre_valid", 32'(valid), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("abort_sample", 32'(sample), 32'd0);
        chk("abort_valid", 32'(valid), 32'd1);
        chk("abort_resultp", 32'(resultp), 32'd0);
        chk("abort_resultn", 32'(resultn), 32'd0);
        chk("abort_dout", 32'(dout), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk($sformatf("post_abort_done_%0d", j), 32'(done), 32'd0);
            chk($sformatf("post_abort_dout_%0d", j), 32'(dout), 32'd0);
        end
        chk("post_abort_valid", 32'(valid), 32'd1);

        chk("sample_valid_excl", 32'(excl_viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic dut_code_bit(input logic [7:0] c, input int b);
        return c[b];
    endfunction
endmodule
